aes_round_sched: RTL and testbench

- Iterative AES-128 encryption round scheduler.
- Accepts one 128-bit plaintext block over a valid/ready handshake and performs the initial AddRoundKey.
- Issues NR round operations to the shared round datapath (SubBytes/ShiftRows/MixColumns chain); the datapath's latency is variable.
- XORs each returned result with the round key, then presents the ciphertext over a valid/ready handshake.
- Sits between the block-level host interface and the round datapath/key-schedule store.

---
 rtl/aes_round_sched_if.sv | 35 +++
 rtl/aes_round_sched.sv | 122 ++++++++++++
 tb/tb_aes_round_sched.sv | 383 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_round_sched_if.sv
// Signal bundle between the AES-128 round scheduler and its host, key store and round datapath.
interface aes_round_sched_if #(
  parameter int unsigned RW = 4
);
  localparam int unsigned BW = 128;

  logic          in_valid;
  logic          in_ready;
  logic [BW-1:0] in_block;
  logic          out_valid;
  logic          out_ready;
  logic [BW-1:0] out_block;
  logic [RW-1:0] rk_idx;
  logic [BW-1:0] rk_data;
  logic          dp_start;
  logic [BW-1:0] dp_state;
  logic          dp_final;
  logic          dp_done;
  logic [BW-1:0] dp_result;
  logic          busy;
  logic [RW-1:0] round;
  logic          err;

  modport slave (
    input  in_valid, in_block, out_ready, rk_data, dp_done, dp_result,
    output in_ready, out_valid, out_block, rk_idx, dp_start, dp_state, dp_final,
           busy, round, err
  );

  modport master (
    output in_valid, in_block, out_ready, rk_data, dp_done, dp_result,
    input  in_ready, out_valid, out_block, rk_idx, dp_start, dp_state, dp_final,
           busy, round, err
  );
endinterface

// File: rtl/aes_round_sched.sv
// Iterative AES-128 round scheduler: initial AddRoundKey, NR datapath rounds with
// per-round key addition, and a wait-with-timeout on each variable-latency round.
module aes_round_sched #(
  parameter int unsigned NR      = 10,
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned RW      = 4
) (
  input logic              clk,
  input logic              rst_n,
  aes_round_sched_if.slave bus
);
  localparam int unsigned BW = 128;
  localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [RW-1:0] LAST = RW'(NR);
  localparam logic [CW-1:0] CNT_LIMIT = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} st_e;

  st_e           st;
  logic [BW-1:0] state_q;
  logic [BW-1:0] out_block_q;
  logic [RW-1:0] round_q;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic [RW-1:0] round_nxt;
  logic [BW-1:0] keyed_c;
  logic          in_ready_q;
  logic          out_valid_q;
  logic          dp_start_q;
  logic          dp_final_q;
  logic          busy_q;
  logic          err_q;

  assign cnt_nxt   = cnt + CW'(1);
  assign round_nxt = round_q + RW'(1);
  assign keyed_c   = bus.dp_result ^ bus.rk_data;

  // Sequencer; every output is a flop updated on the transition that defines it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st          <= IDLE;
      state_q     <= '0;
      out_block_q <= '0;
      round_q     <= '0;
      cnt         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      dp_start_q  <= 1'b0;
      dp_final_q  <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      dp_start_q <= 1'b0;
      unique case (st)
        IDLE: begin
          if (bus.in_valid && in_ready_q) begin
            state_q    <= bus.in_block ^ bus.rk_data;
            round_q    <= RW'(1);
            err_q      <= 1'b0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            dp_start_q <= 1'b1;
            dp_final_q <= (LAST == RW'(1));
            st         <= ISSUE;
          end
        end
        ISSUE: begin
          cnt <= '0;
          st  <= WAIT;
        end
        WAIT: begin
          // A result landing on the timeout boundary still counts.
          if (bus.dp_done) begin
            state_q <= keyed_c;
            if (round_q == LAST) begin
              out_valid_q <= 1'b1;
              out_block_q <= keyed_c;
              st          <= DONE;
            end else begin
              round_q    <= round_nxt;
              dp_start_q <= 1'b1;
              dp_final_q <= (round_nxt == LAST);
              st         <= ISSUE;
            end
          end else if (cnt_nxt == CNT_LIMIT) begin
            err_q      <= 1'b1;
            round_q    <= '0;
            dp_final_q <= 1'b0;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b0;
            st         <= IDLE;
          end else begin
            cnt <= cnt_nxt;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            out_block_q <= '0;
            round_q     <= '0;
            dp_final_q  <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            st          <= IDLE;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_block = out_block_q;
  assign bus.rk_idx    = round_q;
  assign bus.dp_start  = dp_start_q;
  assign bus.dp_state  = state_q;
  assign bus.dp_final  = dp_final_q;
  assign bus.busy      = busy_q;
  assign bus.round     = round_q;
  assign bus.err       = err_q;
endmodule

// File: tb/tb_aes_round_sched.sv
// Bench for aes_round_sched: AES round datapath and key-store models around the
// scheduler, with a queue-based scoreboard checking every ciphertext it presents.
module tb_aes_round_sched;
  localparam int NR_T = 10;

  typedef struct {
    logic [127:0] blk;
    int           lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  aes_round_sched_if #(.RW(4)) bus ();

  aes_round_sched #(.NR(10), .TIMEOUT(64), .RW(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0]   sb  [256];
  logic [127:0] rks [16];
  exp_t         exp_q [$];

  assign bus.rk_data = rks[bus.rk_idx];

  // Datapath model knobs
  int lat_mode, lat_fix, drop_round, ovr_round, ovr_lat;
  bit spur;
  // Monitor state
  bit presented, stall_bad, chk_ready_next, start_prev;
  int starts, final_bad, acc_edge, hs_edge, st3_cyc;
  logic [127:0] cur;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: wait bound expired at cycle %0d", name, cyc);
  endtask

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] inv;
    inv = 8'h01;
    for (int i = 0; i < 254; i++) inv = gmul(inv, b);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] bswap(input logic [127:0] x);
    logic [127:0] o;
    for (int i = 0; i < 16; i++) o[8*i +: 8] = x[8*(15-i) +: 8];
    return o;
  endfunction

  // SubBytes, ShiftRows and (unless final) MixColumns; no key addition.
  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic fin);
    logic [7:0] a [16];
    logic [7:0] b [16];
    logic [127:0] o;
    for (int i = 0; i < 16; i++) a[i] = sb[s[8*i +: 8]];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) b[4*c+r] = a[4*((c+r)%4)+r];
    if (!fin) begin
      for (int c = 0; c < 4; c++) begin
        a[0] = b[4*c]; a[1] = b[4*c+1]; a[2] = b[4*c+2]; a[3] = b[4*c+3];
        b[4*c]   = gmul(8'h02, a[0]) ^ gmul(8'h03, a[1]) ^ a[2] ^ a[3];
        b[4*c+1] = a[0] ^ gmul(8'h02, a[1]) ^ gmul(8'h03, a[2]) ^ a[3];
        b[4*c+2] = a[0] ^ a[1] ^ gmul(8'h02, a[2]) ^ gmul(8'h03, a[3]);
        b[4*c+3] = gmul(8'h03, a[0]) ^ a[1] ^ a[2] ^ gmul(8'h02, a[3]);
      end
    end
    for (int i = 0; i < 16; i++) o[8*i +: 8] = b[i];
    return o;
  endfunction

  task automatic load_key(input logic [127:0] k);
    logic [7:0] w [176];
    logic [7:0] t [4];
    logic [7:0] rc, tmp;
    rc = 8'h01;
    for (int i = 0; i < 16; i++) w[i] = k[8*i +: 8];
    for (int i = 4; i < 44; i++) begin
      for (int j = 0; j < 4; j++) t[j] = w[4*(i-1)+j];
      if (i % 4 == 0) begin
        tmp = t[0];
        t[0] = sb[t[1]] ^ rc; t[1] = sb[t[2]]; t[2] = sb[t[3]]; t[3] = sb[tmp];
        rc = xt(rc);
      end
      for (int j = 0; j < 4; j++) w[4*i+j] = w[4*(i-4)+j] ^ t[j];
    end
    for (int r = 0; r < 16; r++) rks[r] = '0;
    for (int r = 0; r < 11; r++)
      for (int i = 0; i < 16; i++) rks[r][8*i +: 8] = w[16*r+i];
  endtask

  function automatic logic [13:0] ctrl_vec();
    return {bus.in_ready, bus.out_valid, bus.busy, bus.err, bus.dp_start, bus.dp_final,
            bus.round, bus.rk_idx};
  endfunction

  // Round datapath: latches dp_state at dp_start, answers L cycles later.
  initial begin
    int pend, r, l;
    logic [127:0] cap_state;
    logic cap_final;
    bus.dp_done = 1'b0;
    bus.dp_result = '0;
    pend = -1;
    forever begin
      @(negedge clk);
      bus.dp_done = 1'b0;
      if (!rst_n) pend = -1;
      else begin
        if (pend > 0) begin
          pend--;
          if (pend == 0) begin
            bus.dp_done = 1'b1;
            bus.dp_result = aes_round(cap_state, cap_final);
            pend = -1;
          end
        end
        if (bus.dp_start) begin
          cap_state = bus.dp_state;
          cap_final = bus.dp_final;
          r = int'(bus.round);
          l = (r == ovr_round) ? ovr_lat : (lat_mode != 0 ? int'($urandom_range(8, 1)) : lat_fix);
          pend = (r == drop_round) ? -1 : l;
        end
        if (spur) begin
          bus.dp_done = 1'b1;
          bus.dp_result = {$urandom(), $urandom(), $urandom(), $urandom()};
          spur = 1'b0;
        end
      end
    end
  end

  // Monitor / scoreboard
  initial begin
    exp_t e;
    presented = 0; stall_bad = 0; chk_ready_next = 0; start_prev = 0;
    starts = 0; final_bad = 0; acc_edge = 0; hs_edge = 0; st3_cyc = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        presented = 0; chk_ready_next = 0; start_prev = 0; starts = 0; final_bad = 0;
      end else begin
        if (chk_ready_next) begin
          check("in_ready_after_hs", 128'(bus.in_ready), 128'(1));
          chk_ready_next = 0;
        end
        if (bus.in_valid && bus.in_ready) begin
          acc_edge = cyc + 1; starts = 0; final_bad = 0;
        end
        if (bus.dp_start) begin
          if (start_prev) final_bad++;
          starts++;
          if (bus.dp_final != (starts == NR_T)) final_bad++;
          if (bus.round == 4'd3) st3_cyc = cyc;
        end
        start_prev = bus.dp_start;
        if (bus.out_valid && !presented) begin
          presented = 1; stall_bad = 0; cur = bus.out_block;
          if (exp_q.size() == 0) timeout_fail("unexpected_out_valid");
          else begin
            e = exp_q.pop_front();
            check("ciphertext", bus.out_block, e.blk);
            check("dp_start_count", 128'(starts), 128'(NR_T));
            check("dp_final_or_pulse_errors", 128'(final_bad), 128'(0));
            check("in_ready_in_done", 128'(bus.in_ready), 128'(0));
            if (e.lat != 0) check("latency", 128'(cyc + 1 - acc_edge), 128'(e.lat));
          end
        end else if (presented) begin
          if (!bus.out_valid) begin
            check("out_valid_held", 128'(bus.out_valid), 128'(1));
            presented = 0;
          end else if (bus.out_block !== cur) stall_bad = 1;
        end
        if (presented && bus.out_valid && bus.out_ready) begin
          check("out_block_stable", 128'(stall_bad), 128'(0));
          presented = 0; hs_edge = cyc + 1; chk_ready_next = 1;
        end
      end
    end
  end

  task automatic send(input logic [127:0] blk, output int acc);
    bit ok;
    ok = 0;
    bus.in_block = blk;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 2000 && !ok; i++) begin
      @(negedge clk);
      ok = bus.in_ready;
      @(posedge clk); #1;
    end
    acc = cyc;
    if (!ok) timeout_fail("send_accept");
  endtask

  task automatic wait_drain();
    bit ok;
    ok = 0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(negedge clk);
      ok = (exp_q.size() == 0) && !bus.busy && !presented;
    end
    if (!ok) timeout_fail("drain");
    @(posedge clk); #1;
  endtask

  task automatic wait_idle(output int at);
    bit ok;
    ok = 0;
    at = 0;
    for (int i = 0; i < 500 && !ok; i++) begin
      @(negedge clk);
      ok = !bus.busy;
      at = cyc;
    end
    if (!ok) timeout_fail("wait_idle");
    @(posedge clk); #1;
  endtask

  initial begin
    logic [127:0] k1, pt1, ct1, k2, pt2, ct2;
    int a1, a2, t_idle;
    bit ok;
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.in_block = '0; bus.out_ready = 1'b1;
    lat_mode = 0; lat_fix = 1; drop_round = -1; ovr_round = -1; ovr_lat = 0; spur = 0;
    for (int i = 0; i < 256; i++) sb[i] = sbox(8'(i));
    k1  = bswap(128'h000102030405060708090a0b0c0d0e0f);
    pt1 = bswap(128'h00112233445566778899aabbccddeeff);
    ct1 = bswap(128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    k2  = bswap(128'h2b7e151628aed2a6abf7158809cf4f3c);
    pt2 = bswap(128'h3243f6a8885a308d313198a2e0370734);
    ct2 = bswap(128'h3925841d02dc09fbdc118597196a0b32);
    load_key(k1);
    repeat (3) @(posedge clk);
    #1;
    check("reset_ctrl", 128'(ctrl_vec()), 128'(14'h2000));
    check("reset_out_block", bus.out_block, '0);
    check("reset_dp_state", bus.dp_state, '0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // FIPS-197 C.1, datapath latency 1
    exp_q.push_back('{blk: ct1, lat: 21});
    send(pt1, a1);
    bus.in_valid = 1'b0;
    wait_drain();

    // Random latency with a stalled consumer and a stray dp_done in DONE
    lat_mode = 1; bus.out_ready = 1'b0;
    exp_q.push_back('{blk: ct1, lat: 0});
    send(pt1, a1);
    bus.in_valid = 1'b0;
    ok = 0;
    for (int i = 0; i < 2000 && !ok; i++) begin
      @(negedge clk);
      ok = bus.out_valid;
    end
    if (!ok) timeout_fail("wait_out_valid");
    @(posedge clk); #1;
    spur = 1;
    repeat (4) @(posedge clk);
    #1;
    check("done_round_held", 128'(bus.round), 128'(10));
    bus.out_ready = 1'b1;
    wait_drain();
    lat_mode = 0;

    // Stray dp_done in IDLE
    spur = 1;
    repeat (3) @(posedge clk);
    #1;
    check("idle_after_spurious", 128'(ctrl_vec()), 128'(14'h2000));

    // Back-to-back with in_valid held high, latency 2
    lat_fix = 2;
    exp_q.push_back('{blk: ct1, lat: 31});
    exp_q.push_back('{blk: ct1, lat: 31});
    send(pt1, a1);
    send(pt1, a2);
    bus.in_valid = 1'b0;
    check("b2b_accept_after_hs", 128'(a2 - hs_edge), 128'(1));
    wait_drain();
    lat_fix = 1;

    // Datapath silent in round 3
    drop_round = 3;
    send(pt1, a1);
    bus.in_valid = 1'b0;
    wait_idle(t_idle);
    check("timeout_cycles", 128'(t_idle - st3_cyc), 128'(64));
    check("timeout_ctrl", 128'(ctrl_vec()), 128'(14'h2400));
    drop_round = -1;
    exp_q.push_back('{blk: ct1, lat: 21});
    send(pt1, a1);
    bus.in_valid = 1'b0;
    check("err_cleared_on_accept", 128'(bus.err), 128'(0));
    wait_drain();

    // dp_done exactly on the timeout boundary
    ovr_round = 2; ovr_lat = 63;
    exp_q.push_back('{blk: ct1, lat: 83});
    send(pt1, a1);
    bus.in_valid = 1'b0;
    wait_drain();
    check("boundary_err_clear", 128'(bus.err), 128'(0));

    // dp_done one cycle past the boundary
    ovr_lat = 64;
    send(pt1, a1);
    bus.in_valid = 1'b0;
    wait_idle(t_idle);
    repeat (3) @(posedge clk);
    #1;
    check("late_done_timeout", 128'(ctrl_vec()), 128'(14'h2400));
    ovr_round = -1;

    // Asynchronous reset during WAIT of round 5
    lat_fix = 4;
    exp_q.push_back('{blk: ct1, lat: 0});
    send(pt1, a1);
    bus.in_valid = 1'b0;
    ok = 0;
    for (int i = 0; i < 500 && !ok; i++) begin
      @(negedge clk);
      ok = bus.busy && (bus.round == 4'd5) && !bus.dp_start;
    end
    if (!ok) timeout_fail("wait_round5");
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("async_reset_ctrl", 128'(ctrl_vec()), 128'(14'h2000));
    check("async_reset_dp_state", bus.dp_state, '0);
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    load_key(k2);
    exp_q.push_back('{blk: ct2, lat: 51});
    send(pt2, a1);
    bus.in_valid = 1'b0;
    wait_drain();

    check("scoreboard_empty", 128'(exp_q.size()), 128'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
